rf_arbiter: RTL and testbench
=============================

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register-file word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width (2**ADDR_W entries).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports a_valid/b_valid  input  1  requester A/B command valid.
REQ-006 SHALL have ports a_ready/b_ready  output  1  command accepted this cycle.
REQ-007 SHALL have ports a_we/b_we  input  1  1=write, 0=read.
REQ-008 SHALL have ports a_addr/b_addr  input  ADDR_W  entry index.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports a_rsp_valid/b_rsp_valid  output  1  read data valid pulse.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-012 SHALL have ports rf_we  output  1, rf_addr  output  ADDR_W, rf_wdata  output  DATA_W  register-file command.
REQ-013 SHALL have port rf_rdata  input  DATA_W  register-file read data, one cycle after rf_addr.
REQ-014 SHALL have port busy  output  1  high while not accepting commands.

Function
REQ-015 SHALL implement FSM states CLEAR and RUN; ready is asserted only in RUN.
REQ-016 In RUN, with only one valid, that requester SHALL be granted in the same cycle (ready combinational from valid and state).
REQ-017 With both valid, SHALL grant the requester not granted most recently; last_grant updates only on a grant.
REQ-018 Grant means valid&&ready; at most one grant per cycle; grants may occur every cycle.
REQ-019 On a grant, rf_we/rf_addr/rf_wdata SHALL carry the granted command that same cycle; with no grant, rf_we=0, rf_addr and rf_wdata=0.
REQ-020 A granted read SHALL produce a one-cycle x_rsp_valid pulse to the granting requester in the next cycle, with rsp_rdata=rf_rdata; latency exactly 1 cycle.
REQ-021 A granted write SHALL produce no response pulse.
REQ-022 rsp_rdata SHALL be 0 in cycles with no rsp_valid.
REQ-023 a_rsp_valid and b_rsp_valid SHALL never be high together.
REQ-024 Back-to-back write then read of the same address SHALL return the written data (RF has synchronous write, registered read).
REQ-025 Responses have no back-pressure; requesters always accept.
REQ-026 A requester holding valid SHALL be granted within 2 cycles (starvation-free).
REQ-027 Command inputs not granted SHALL be ignored; no command is queued internally.

Reset
REQ-028 rst_n low SHALL immediately force ready=0, rsp_valid=0, rsp_rdata=0, rf_we=0, rf_addr=0, rf_wdata=0, last_grant=B (so A wins the first tie).
REQ-029 A read granted in the cycle before reset assertion SHALL have its response discarded.
REQ-030 After rst_n deasserts, the FSM SHALL enter CLEAR if RF_ARB_CLEAR_EN is defined, else RUN.

Configuration
REQ-031 Macro RF_ARB_CLEAR_EN SHALL compile in the clear sequencer.
REQ-032 With it: CLEAR drives rf_we=1, rf_wdata=0, rf_addr=counter 0..2**ADDR_W-1, one entry per cycle; busy=1, both ready=0; after the final entry, RUN with busy=0.
REQ-033 With it: reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-034 Without it: no counter, no CLEAR state, busy tied 0, RUN directly after reset.

Verification
REQ-035 A write addr 3 data 0x1122334455667788, next cycle A read addr 3 -> a_ready=1 both cycles, a_rsp_valid one cycle later with rsp_rdata=0x1122334455667788.
REQ-036 A and B both valid reads for 4 cycles -> grants A,B,A,B; rsp pulses alternate a,b,a,b with 1-cycle lag.
REQ-037 B holds valid while A issues back-to-back -> B granted no later than the second cycle.
REQ-038 With RF_ARB_CLEAR_EN: release reset -> busy=1 and rf_we=1 for 32 cycles, addresses 0..31, then busy=0; a read of addr 31 returns 0.
REQ-039 Assert rst_n low one cycle after granting A read addr 7 -> no a_rsp_valid; all outputs 0 during reset.
REQ-040 Without RF_ARB_CLEAR_EN: first cycle after reset release, A valid write -> a_ready=1, busy never 1.

Source files
------------

// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Define RF_ARB_CLEAR_EN to zero every entry after reset before commands are accepted.
module rf_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              state_dbg
);

  // Handshake: a command transfers in any cycle where x_valid && x_ready.
  // x_ready is combinational from both valids and the state; responses have
  // no ready and are always taken by the requester.

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t state;
  logic   clearing;
  logic   in_run;
  logic   grant_a;
  logic   grant_b;
  logic   last_b;
  logic   rsp_a_q;
  logic   rsp_b_q;

`ifdef RF_ARB_CLEAR_EN
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_d = clr_cnt + 1'b1;
      if (clr_cnt == {ADDR_W{1'b1}}) state_d = RUN;
    end
  end

  assign clearing = rst_n && (state == CLEAR);
`else
  assign state    = RUN;
  assign clearing = 1'b0;
`endif

  // rst_n gates the combinational outputs so they drop the moment reset asserts.
  assign in_run    = rst_n && (state == RUN);
  assign grant_a   = in_run && a_valid && (!b_valid || last_b);
  assign grant_b   = in_run && b_valid && !grant_a;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign busy      = clearing;
  assign state_dbg = (state == RUN);

  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    if (grant_a) begin
      rf_we    = a_we;
      rf_addr  = a_addr;
      rf_wdata = a_wdata;
    end else if (grant_b) begin
      rf_we    = b_we;
      rf_addr  = b_addr;
      rf_wdata = b_wdata;
    end
`ifdef RF_ARB_CLEAR_EN
    else if (clearing) begin
      rf_we   = 1'b1;
      rf_addr = clr_cnt;
    end
`endif
  end

  // last_b resets high so A wins the first tie; a pending read response is
  // dropped when reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b  <= 1'b1;
      rsp_a_q <= 1'b0;
      rsp_b_q <= 1'b0;
    end else begin
      if (grant_a || grant_b) last_b <= grant_b;
      rsp_a_q <= grant_a && !a_we;
      rsp_b_q <= grant_b && !b_we;
    end
  end

  assign a_rsp_valid = rsp_a_q;
  assign b_rsp_valid = rsp_b_q;
  assign rsp_rdata   = (rsp_a_q || rsp_b_q) ? rf_rdata : '0;

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: register-file stub, reference model with scoreboard,
// and a separate response monitor. Tracks RF_ARB_CLEAR_EN like the design.
module tb_rf_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NENT   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, a_ready, a_we, a_rsp_valid;
  logic              b_valid, b_ready, b_we, b_rsp_valid;
  logic [ADDR_W-1:0] a_addr, b_addr, rf_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, rsp_rdata, rf_wdata;
  logic [DATA_W-1:0] rf_rdata = '0;
  logic              rf_we, busy, state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rf_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
    .rsp_rdata(rsp_rdata), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // register-file stub: synchronous write, registered read
  logic [DATA_W-1:0] rf_mem [NENT];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_addr];
  end

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 64'h0123_4567_89AB_0000 + 64'(i) * 64'h0000_0001_0000_0101;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // reference model: shadow memory, round-robin by "whoever lost last", clear counter
  logic [DATA_W-1:0] mem_m [NENT];
  logic [DATA_W:0]   exp_q[$];   // {is_b, data}
  int                due_q[$];
  logic              last_b_m;
  int                clr_cnt_m;
  logic              ga, gb, run_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_b_m  = 1'b1;
      clr_cnt_m = 0;
      check("reset_ctrl", {58'd0, a_ready, b_ready, a_rsp_valid, b_rsp_valid, rf_we, busy}, '0);
      check("reset_rf_addr", rf_addr, '0);
      check("reset_rf_wdata", rf_wdata, '0);
      check("reset_rsp_rdata", rsp_rdata, '0);
    end else begin
      run_m = 1'b1;
`ifdef RF_ARB_CLEAR_EN
      if (clr_cnt_m < NENT) begin
        run_m = 1'b0;
        check("clr_ready", {a_ready, b_ready}, '0);
        check("clr_busy", busy, 1);
        check("clr_we", rf_we, 1);
        check("clr_addr", rf_addr, clr_cnt_m);
        check("clr_wdata", rf_wdata, '0);
        mem_m[clr_cnt_m] = '0;
        clr_cnt_m++;
      end
`endif
      if (run_m) begin
        ga = a_valid && (!b_valid || last_b_m);
        gb = b_valid && !ga;
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("busy", busy, 0);
        if (ga || gb) begin
          logic              we_m;
          logic [ADDR_W-1:0] ad_m;
          logic [DATA_W-1:0] wd_m;
          we_m = ga ? a_we : b_we;
          ad_m = ga ? a_addr : b_addr;
          wd_m = ga ? a_wdata : b_wdata;
          check("rf_we", rf_we, we_m);
          check("rf_addr", rf_addr, ad_m);
          if (we_m) begin
            check("rf_wdata", rf_wdata, wd_m);
            mem_m[ad_m] = wd_m;
          end else begin
            exp_q.push_back({gb, mem_m[ad_m]});
            due_q.push_back(cyc + 1);
          end
          last_b_m = gb;
        end else begin
          check("idle_rf", {58'd0, rf_we, rf_addr}, '0);
          check("idle_wdata", rf_wdata, '0);
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
    end else begin
      check("rsp_exclusive", a_rsp_valid && b_rsp_valid, 0);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("rsp_who", {a_rsp_valid, b_rsp_valid}, e[DATA_W] ? 2'b01 : 2'b10);
        check("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
      end else begin
        check("rsp_none", {a_rsp_valid, b_rsp_valid}, '0);
        check("rsp_rdata_zero", rsp_rdata, '0);
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic av, input logic aw, input int aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic bw, input int ba, input logic [DATA_W-1:0] bd);
    a_valid = av; a_we = aw; a_addr = ADDR_W'(aa); a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ADDR_W'(ba); b_wdata = bd;
  endtask

  task automatic drive(input logic av, input logic aw, input int aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic bw, input int ba, input logic [DATA_W-1:0] bd);
    @(posedge clk);
    #1;
    set_in(av, aw, aa, ad, bv, bw, ba, bd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic wait_clear();
`ifdef RF_ARB_CLEAR_EN
    idle(NENT + 1);
`endif
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) begin
      rf_mem[i] = init_val(i);
      mem_m[i]  = init_val(i);
    end
    rst_n = 1'b0;
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    // write presented in the very first cycle after release
    rst_n = 1'b1;
    set_in(1, 1, 9, 64'hDEAD_BEEF_0000_0009, 0, 0, 0, '0);
    wait_clear();

    // write then read of the same address back-to-back
    drive(1, 1, 3, 64'h1122_3344_5566_7788, 0, 0, 0, '0);
    drive(1, 0, 3, '0, 0, 0, 0, '0);
    drive(0, 0, 0, '0, 0, 0, 0, '0);

    // both reading for four cycles
    for (int i = 0; i < 4; i++) drive(1, 0, i, '0, 1, 0, 31 - i, '0);
    idle(1);

    // B held while A issues back-to-back
    drive(1, 1, 12, 64'hA0A0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(1, 0, 12 + i, '0, 1, 0, 9, '0);
    idle(1);

    // last entry
    drive(1, 0, 31, '0, 0, 0, 0, '0);
    idle(1);

    // reset asserted the cycle after granting a read
    drive(1, 0, 7, '0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear();

    // randomized traffic, addresses kept narrow for read-after-write collisions
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            {$urandom, $urandom});
    end
    idle(3);
    @(negedge clk);
    check("rsp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
